// File: rtl/rs_allocator.sv
// Reservation-station array: allocates dispatched ops, captures CDB results, frees issued entries.
// Latency: dispatch, CDB wakeup and issue-free each become visible in res_stations one cycle later.
// Backpressure: disp_ready = !full. A dispatch seen while full is dropped and must be held by the sender.
package rs_pkg;
    localparam int RS_SIZE = 8;
    localparam int ROB_W   = 4;
    localparam int LSQ_W   = 4;
    localparam int RS_W    = 4;

    typedef struct packed {
        logic [5:0] alu_op;
        logic       is_load;
        logic       is_store;
        logic       is_branch;
        logic       uses_imm;
        logic [5:0] rsvd;
    } control_bits;

    typedef struct packed {
        logic              busy;
        logic [RS_W-1:0]   id;
        logic [ROB_W-1:0]  tag;
        logic [LSQ_W-1:0]  lsq_id;
        logic [ROB_W-1:0]  tag_1;
        logic [31:0]       value_1;
        logic [ROB_W-1:0]  tag_2;
        logic [31:0]       value_2;
        logic [31:0]       imm;
        control_bits       ctrl_bits;
    } rs_entry;

    typedef struct packed {
        logic [ROB_W-1:0] tag;
        logic [31:0]      value;
    } operand_t;
endpackage

module rs_allocator #(
    parameter int RS_SIZE = rs_pkg::RS_SIZE,
    parameter int ROB_W   = rs_pkg::ROB_W,
    parameter int LSQ_W   = rs_pkg::LSQ_W,
    parameter int RS_W    = rs_pkg::RS_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                disp_valid,
    output logic                disp_ready,
    input  logic [ROB_W-1:0]    disp_tag,
    input  logic [LSQ_W-1:0]    disp_lsq_id,
    input  logic [ROB_W-1:0]    disp_tag_1,
    input  logic [ROB_W-1:0]    disp_tag_2,
    input  logic [31:0]         disp_value_1,
    input  logic [31:0]         disp_value_2,
    input  logic [31:0]         disp_imm,
    input  rs_pkg::control_bits disp_ctrl,
    input  logic                cdb_a_valid,
    input  logic                cdb_b_valid,
    input  logic [ROB_W-1:0]    cdb_a_tag,
    input  logic [ROB_W-1:0]    cdb_b_tag,
    input  logic [31:0]         cdb_a_value,
    input  logic [31:0]         cdb_b_value,
    input  logic [RS_W-1:0]     issue_rs_id,
    output rs_pkg::rs_entry     res_stations [RS_SIZE],
    output logic                full,
    output logic [RS_W-1:0]     free_count
);
    logic [RS_W-1:0] free_cnt;
    logic [RS_W-1:0] alloc_idx;
    logic            alloc_en;
    rs_pkg::rs_entry alloc_entry;

    // Tag 0 is "already ready" so it short-circuits before any CDB compare; A wins over B.
    function automatic rs_pkg::operand_t resolve(input logic [ROB_W-1:0] tag,
                                                  input logic [31:0] value,
                                                  input logic [31:0] miss_value);
        rs_pkg::operand_t r;
        if (tag == '0) begin
            r = '{tag: '0, value: value};
        end else if (cdb_a_valid && cdb_a_tag == tag) begin
            r = '{tag: '0, value: cdb_a_value};
        end else if (cdb_b_valid && cdb_b_tag == tag) begin
            r = '{tag: '0, value: cdb_b_value};
        end else begin
            r = '{tag: tag, value: miss_value};
        end
        return r;
    endfunction

    function automatic rs_pkg::rs_entry blank_entry(input int idx);
        rs_pkg::rs_entry e;
        e    = '0;
        e.id = RS_W'(idx + 1);
        return e;
    endfunction

    // Downward scan so the last write leaves the lowest free index.
    always_comb begin
        free_cnt  = '0;
        alloc_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!res_stations[i].busy) begin
                free_cnt  = free_cnt + RS_W'(1);
                alloc_idx = RS_W'(i);
            end
        end
    end

    assign free_count = free_cnt;
    assign full       = (free_cnt == '0);
    assign disp_ready = !full;
    assign alloc_en   = disp_valid && !full;

    always_comb begin
        alloc_entry           = '0;
        alloc_entry.busy      = 1'b1;
        alloc_entry.id        = alloc_idx + RS_W'(1);
        alloc_entry.tag       = disp_tag;
        alloc_entry.lsq_id    = disp_lsq_id;
        alloc_entry.imm       = disp_imm;
        alloc_entry.ctrl_bits = disp_ctrl;
        {alloc_entry.tag_1, alloc_entry.value_1} = resolve(disp_tag_1, disp_value_1, 32'h0);
        {alloc_entry.tag_2, alloc_entry.value_2} = resolve(disp_tag_2, disp_value_2, 32'h0);
    end

    // Allocation only ever targets a non-busy slot, so it cannot collide with a real issue-free.
    always_ff @(posedge clk) begin
        for (int i = 0; i < RS_SIZE; i++) begin
            if (reset || flush) begin
                res_stations[i] <= blank_entry(i);
            end else if (alloc_en && alloc_idx == RS_W'(i)) begin
                res_stations[i] <= alloc_entry;
            end else if (issue_rs_id == RS_W'(i + 1)) begin
                res_stations[i] <= blank_entry(i);
            end else if (res_stations[i].busy) begin
                {res_stations[i].tag_1, res_stations[i].value_1} <=
                    resolve(res_stations[i].tag_1, res_stations[i].value_1, res_stations[i].value_1);
                {res_stations[i].tag_2, res_stations[i].value_2} <=
                    resolve(res_stations[i].tag_2, res_stations[i].value_2, res_stations[i].value_2);
            end
        end
    end
endmodule

// File: tb/tb_rs_allocator.sv
// Directed scenarios plus randomized traffic against a behavioural reservation-station model.
module tb_rs_allocator;
    import rs_pkg::*;
    localparam int N = 8;

    logic        clk = 1'b0;
    logic        reset, flush, disp_valid, disp_ready;
    logic [3:0]  disp_tag, disp_lsq_id, disp_tag_1, disp_tag_2;
    logic [31:0] disp_value_1, disp_value_2, disp_imm;
    control_bits disp_ctrl;
    logic        cdb_a_valid, cdb_b_valid;
    logic [3:0]  cdb_a_tag, cdb_b_tag;
    logic [31:0] cdb_a_value, cdb_b_value;
    logic [3:0]  issue_rs_id;
    rs_entry     res_stations [N];
    logic        full;
    logic [3:0]  free_count;

    rs_entry     m [N];
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    rs_allocator dut (
        .clk(clk), .reset(reset), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_tag(disp_tag), .disp_lsq_id(disp_lsq_id),
        .disp_tag_1(disp_tag_1), .disp_tag_2(disp_tag_2),
        .disp_value_1(disp_value_1), .disp_value_2(disp_value_2),
        .disp_imm(disp_imm), .disp_ctrl(disp_ctrl),
        .cdb_a_valid(cdb_a_valid), .cdb_b_valid(cdb_b_valid),
        .cdb_a_tag(cdb_a_tag), .cdb_b_tag(cdb_b_tag),
        .cdb_a_value(cdb_a_value), .cdb_b_value(cdb_b_value),
        .issue_rs_id(issue_rs_id), .res_stations(res_stations),
        .full(full), .free_count(free_count)
    );

    function automatic rs_entry empty_slot(input int i);
        rs_entry e;
        e    = '0;
        e.id = 4'(i + 1);
        return e;
    endfunction

    function automatic logic cdb_hit(input logic [3:0] t, output logic [31:0] v);
        v = 32'h0;
        if (t == 4'd0) return 1'b0;
        if (cdb_a_valid && cdb_a_tag == t) begin v = cdb_a_value; return 1'b1; end
        if (cdb_b_valid && cdb_b_tag == t) begin v = cdb_b_value; return 1'b1; end
        return 1'b0;
    endfunction

    function automatic int model_free();
        int n = 0;
        for (int i = 0; i < N; i++) if (!m[i].busy) n++;
        return n;
    endfunction

    task automatic model_step();
        rs_entry     nxt [N];
        int          target = -1;
        logic [31:0] v;
        if (disp_valid && model_free() > 0)
            for (int i = N - 1; i >= 0; i--) if (!m[i].busy) target = i;
        for (int i = 0; i < N; i++) begin
            nxt[i] = m[i];
            if (m[i].busy && int'(issue_rs_id) == i + 1) begin
                nxt[i] = empty_slot(i);
            end else if (m[i].busy) begin
                if (cdb_hit(m[i].tag_1, v)) begin nxt[i].tag_1 = 0; nxt[i].value_1 = v; end
                if (cdb_hit(m[i].tag_2, v)) begin nxt[i].tag_2 = 0; nxt[i].value_2 = v; end
            end
        end
        if (target >= 0) begin
            nxt[target]           = empty_slot(target);
            nxt[target].busy      = 1'b1;
            nxt[target].tag       = disp_tag;
            nxt[target].lsq_id    = disp_lsq_id;
            nxt[target].imm       = disp_imm;
            nxt[target].ctrl_bits = disp_ctrl;
            if (disp_tag_1 == 0)             nxt[target].value_1 = disp_value_1;
            else if (cdb_hit(disp_tag_1, v)) nxt[target].value_1 = v;
            else                             nxt[target].tag_1   = disp_tag_1;
            if (disp_tag_2 == 0)             nxt[target].value_2 = disp_value_2;
            else if (cdb_hit(disp_tag_2, v)) nxt[target].value_2 = v;
            else                             nxt[target].tag_2   = disp_tag_2;
        end
        if (reset || flush)
            for (int i = 0; i < N; i++) nxt[i] = empty_slot(i);
        m = nxt;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 0; flush = 0; disp_valid = 0;
        disp_tag = 0; disp_lsq_id = 0; disp_tag_1 = 0; disp_tag_2 = 0;
        disp_value_1 = 0; disp_value_2 = 0; disp_imm = 0; disp_ctrl = '0;
        cdb_a_valid = 0; cdb_b_valid = 0; cdb_a_tag = 0; cdb_b_tag = 0;
        cdb_a_value = 0; cdb_b_value = 0; issue_rs_id = 0;
    endtask

    task automatic dispatch(input logic [3:0] tag, input logic [3:0] t1, input logic [31:0] v1,
                            input logic [3:0] t2, input logic [31:0] v2);
        disp_valid = 1; disp_tag = tag; disp_lsq_id = tag ^ 4'hA;
        disp_tag_1 = t1; disp_value_1 = v1; disp_tag_2 = t2; disp_value_2 = v2;
        disp_imm = 32'h1000 + 32'(tag); disp_ctrl = control_bits'(16'h0A50 | 16'(tag));
    endtask

    task automatic do_reset();
        idle(); reset = 1; tick(); tick(); idle();
    endtask

    task automatic test_reset();
        rs_entry exp;
        do_reset();
        for (int i = 0; i < N; i++) begin
            exp = '0; exp.id = 4'(i + 1);
            vectors++;
            if (res_stations[i] !== exp) begin
                miscompares++;
                $display("FAIL reset_entry%0d got %h want %h", i, res_stations[i], exp);
            end
        end
        vectors++;
        if (free_count !== 4'd8 || full !== 1'b0 || disp_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_counts got free=%0d full=%b rdy=%b want 8/0/1", free_count, full, disp_ready);
        end
    endtask

    task automatic test_alloc_basic();
        dispatch(4'd3, 4'd0, 32'd5, 4'd0, 32'd7); tick(); idle();
        vectors++;
        if (res_stations[0].busy !== 1'b1 || res_stations[0].id !== 4'd1 || res_stations[0].tag !== 4'd3 ||
            res_stations[0].value_1 !== 32'd5 || res_stations[0].value_2 !== 32'd7) begin
            miscompares++;
            $display("FAIL alloc_entry0 got %h want busy=1 id=1 tag=3 v1=5 v2=7", res_stations[0]);
        end
        vectors++;
        if (free_count !== 4'd7) begin
            miscompares++;
            $display("FAIL alloc_free got %0d want 7", free_count);
        end
    endtask

    task automatic test_wakeup();
        dispatch(4'd4, 4'd2, 32'h0, 4'd0, 32'd1); tick();
        dispatch(4'd5, 4'd0, 32'd9, 4'd2, 32'h0); tick(); idle();
        vectors++;
        if (res_stations[1].tag_1 !== 4'd2 || res_stations[2].tag_2 !== 4'd2) begin
            miscompares++;
            $display("FAIL wake_pending got t1=%0d t2=%0d want 2/2", res_stations[1].tag_1, res_stations[2].tag_2);
        end
        cdb_a_valid = 1; cdb_a_tag = 4'd2; cdb_a_value = 32'hAB; tick(); idle();
        vectors++;
        if (res_stations[1].tag_1 !== 4'd0 || res_stations[1].value_1 !== 32'hAB) begin
            miscompares++;
            $display("FAIL wake_src1 got t=%0d v=%h want 0/ab", res_stations[1].tag_1, res_stations[1].value_1);
        end
        vectors++;
        if (res_stations[2].tag_2 !== 4'd0 || res_stations[2].value_2 !== 32'hAB) begin
            miscompares++;
            $display("FAIL wake_src2 got t=%0d v=%h want 0/ab", res_stations[2].tag_2, res_stations[2].value_2);
        end
    endtask

    task automatic test_bypass();
        dispatch(4'd8, 4'd6, 32'h0, 4'd0, 32'd3);
        cdb_b_valid = 1; cdb_b_tag = 4'd6; cdb_b_value = 32'h11; tick(); idle();
        vectors++;
        if (res_stations[3].tag_1 !== 4'd0 || res_stations[3].value_1 !== 32'h11) begin
            miscompares++;
            $display("FAIL bypass_b got t=%0d v=%h want 0/11", res_stations[3].tag_1, res_stations[3].value_1);
        end
        dispatch(4'd9, 4'd6, 32'h0, 4'd7, 32'hDEAD);
        cdb_a_valid = 1; cdb_a_tag = 4'd6; cdb_a_value = 32'd1;
        cdb_b_valid = 1; cdb_b_tag = 4'd6; cdb_b_value = 32'd2; tick(); idle();
        vectors++;
        if (res_stations[4].tag_1 !== 4'd0 || res_stations[4].value_1 !== 32'd1) begin
            miscompares++;
            $display("FAIL bypass_a_over_b got t=%0d v=%h want 0/1", res_stations[4].tag_1, res_stations[4].value_1);
        end
        vectors++;
        if (res_stations[4].tag_2 !== 4'd7 || res_stations[4].value_2 !== 32'd0) begin
            miscompares++;
            $display("FAIL bypass_miss got t=%0d v=%h want 7/0", res_stations[4].tag_2, res_stations[4].value_2);
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < N; i++) begin dispatch(4'(i + 1), 4'd0, 32'(i), 4'd0, 32'(i)); tick(); end
        idle();
        vectors++;
        if (full !== 1'b1 || disp_ready !== 1'b0 || free_count !== 4'd0) begin
            miscompares++;
            $display("FAIL full_flags got full=%b rdy=%b free=%0d want 1/0/0", full, disp_ready, free_count);
        end
        dispatch(4'd12, 4'd0, 32'h0, 4'd0, 32'h0); tick();
        for (int i = 0; i < N; i++) begin
            vectors++;
            if (res_stations[i].tag !== 4'(i + 1) || res_stations[i].busy !== 1'b1) begin
                miscompares++;
                $display("FAIL full_hold%0d got tag=%0d busy=%b want %0d/1", i, res_stations[i].tag, res_stations[i].busy, i + 1);
            end
        end
        dispatch(4'd13, 4'd0, 32'h0, 4'd0, 32'h0); issue_rs_id = 4'd3; tick();
        vectors++;
        if (res_stations[2].busy !== 1'b0 || free_count !== 4'd1) begin
            miscompares++;
            $display("FAIL full_free got busy=%b free=%0d want 0/1", res_stations[2].busy, free_count);
        end
        issue_rs_id = 4'd0; tick(); idle();
        vectors++;
        if (res_stations[2].busy !== 1'b1 || res_stations[2].tag !== 4'd13 || full !== 1'b1) begin
            miscompares++;
            $display("FAIL full_reuse got busy=%b tag=%0d full=%b want 1/13/1", res_stations[2].busy, res_stations[2].tag, full);
        end
    endtask

    task automatic test_issue_free();
        do_reset();
        dispatch(4'd7, 4'd9, 32'h0, 4'd0, 32'd4); tick();
        dispatch(4'd10, 4'd9, 32'h0, 4'd0, 32'd4); tick(); idle();
        issue_rs_id = 4'd1; cdb_a_valid = 1; cdb_a_tag = 4'd9; cdb_a_value = 32'h55; tick(); idle();
        vectors++;
        if (res_stations[0] !== empty_slot(0)) begin
            miscompares++;
            $display("FAIL issue_clear got %h want %h", res_stations[0], empty_slot(0));
        end
        vectors++;
        if (res_stations[1].tag_1 !== 4'd0 || res_stations[1].value_1 !== 32'h55 || free_count !== 4'd7) begin
            miscompares++;
            $display("FAIL issue_neighbour got t=%0d v=%h free=%0d want 0/55/7",
                     res_stations[1].tag_1, res_stations[1].value_1, free_count);
        end
    endtask

    task automatic test_flush_reset();
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            for (int i = 0; i < 5; i++) begin dispatch(4'(i + 1), 4'd0, 32'h0, 4'd9, 32'h0); tick(); end
            vectors++;
            if (free_count !== 4'd3) begin
                miscompares++;
                $display("FAIL clear%0d_pre got free=%0d want 3", pass, free_count);
            end
            dispatch(4'd14, 4'd0, 32'h0, 4'd0, 32'h0);
            cdb_a_valid = 1; cdb_a_tag = 4'd9; cdb_a_value = 32'h77;
            if (pass == 0) flush = 1; else reset = 1;
            tick(); idle();
            for (int i = 0; i < N; i++) begin
                vectors++;
                if (res_stations[i] !== empty_slot(i)) begin
                    miscompares++;
                    $display("FAIL clear%0d_entry%0d got %h want %h", pass, i, res_stations[i], empty_slot(i));
                end
            end
            vectors++;
            if (free_count !== 4'd8 || full !== 1'b0) begin
                miscompares++;
                $display("FAIL clear%0d_counts got free=%0d full=%b want 8/0", pass, free_count, full);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            idle();
            reset = ($urandom_range(0, 199) == 0);
            flush = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 9) < 6)
                dispatch(4'($urandom_range(0, 15)),
                         ($urandom_range(0, 9) < 4) ? 4'd0 : 4'($urandom_range(1, 7)), $urandom,
                         ($urandom_range(0, 9) < 4) ? 4'd0 : 4'($urandom_range(1, 7)), $urandom);
            disp_ctrl   = control_bits'(16'($urandom));
            cdb_a_valid = $urandom_range(0, 1) == 1;
            cdb_a_tag   = 4'($urandom_range(0, 7));
            cdb_a_value = $urandom;
            cdb_b_valid = $urandom_range(0, 1) == 1;
            cdb_b_tag   = 4'($urandom_range(0, 7));
            cdb_b_value = $urandom;
            issue_rs_id = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 10)) : 4'd0;
            tick();
            for (int i = 0; i < N; i++) begin
                vectors++;
                if (res_stations[i] !== m[i]) begin
                    miscompares++;
                    $display("FAIL rand_entry%0d cyc %0d got %h want %h", i, c, res_stations[i], m[i]);
                end
            end
            vectors++;
            if (int'(free_count) !== model_free() || full !== (model_free() == 0) || disp_ready !== (model_free() != 0)) begin
                miscompares++;
                $display("FAIL rand_counts cyc %0d got free=%0d full=%b want free=%0d", c, free_count, full, model_free());
            end
        end
        idle();
    endtask

    initial begin
        idle();
        reset = 1;
        test_reset();
        test_alloc_basic();
        test_wakeup();
        test_bypass();
        test_full();
        test_issue_free();
        test_flush_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
